error_recovery_unit: RTL and testbench
======================================

// Module: error_recovery_unit
// PURPOSE
//  Sequential recovery stage paired with the approximate compressor layers. It consumes the
//  approximate product g and the error vector ep those layers emit, and returns the corrected
//  product p = g + ep, using only ep bits inside the recovery window.
//  Addition is chunk-serial with registered carry, for small area. Sits between the final
//  approximate layer and the product consumer, with valid/ready on both sides.
// PARAMETERS
//  WIDTH        32  product/error vector width; must be a multiple of CHUNK (elaboration error otherwise)
//  CHUNK         8  bits added per cycle; NCHUNK = WIDTH/CHUNK
//  RECOVER_LSB   9  lowest ep bit honoured; ep bits below it are masked to 0
//  RECOVER_MSB  24  highest ep bit honoured; ep bits above it are masked to 0
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      g_in/ep_in/recover_en valid
//  in_ready    out  1      unit can accept an operand set
//  g_in        in   WIDTH  approximate product; bit k has weight 2^k
//  ep_in       in   WIDTH  error vector; bit k has weight 2^k
//  recover_en  in   1      1: apply masked ep; 0: bypass, ep treated as 0
//  out_valid   out  1      p_out valid
//  out_ready   in   1      consumer accepts p_out
//  p_out       out  WIDTH  corrected product, mod 2^WIDTH
//  err_flag    out  1      masked ep of this result was nonzero
//  ovf         out  1      carry out of bit WIDTH-1 was discarded
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n low, 1 from first edge after release;
//   out_valid=0; p_out=0; err_flag=0; ovf=0; busy=0; idx=0; carry=0.
//  FSM IDLE -> ADD -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready at edge T:
//   - latch g_in as G;
//   - latch M = recover_en ? (ep_in & mask[RECOVER_MSB:RECOVER_LSB]) : 0;
//   - err_flag <= |M; idx <= 0; carry <= 0; go to ADD.
//  ADD: in_ready=0. Each edge computes {c,s} = G[idx*CHUNK +: CHUNK] + M[idx*CHUNK +: CHUNK] + carry.
//   Then p_out[idx slice] <= s; carry <= c; idx++.
//   After the slice with idx=NCHUNK-1: ovf <= c; go to DONE.
//  DONE: out_valid=1. p_out/err_flag/ovf are held stable until out_ready=1 at an edge,
//   then out_valid <= 0 and state goes to IDLE.
//  Latency: accept edge T -> out_valid high after edge T+NCHUNK (4 for defaults), independent of
//   recover_en and data. Throughput: one result per NCHUNK+2 cycles minimum (accept, NCHUNK adds, drain).
//  p_out is driven only from the result register; partial slices are visible while busy but are
//   don't-care until out_valid=1. p_out keeps its last value after drain until overwritten.
//  Inputs are sampled only at the accept edge; changes to g_in/ep_in/recover_en while busy are ignored.
//  in_valid while busy is not accepted; the producer must hold it until in_ready.
//  out_ready while out_valid=0 has no effect.
//  RECOVER_LSB>RECOVER_MSB gives an empty window: always bypass, err_flag=0.
//  Reset mid-operation: the in-flight operation is dropped, no out_valid pulse, all regs to reset values.
// TESTING
//  T1 basic: g=0x0000_1234, ep=0x0000_0200, en=1 -> p=0x0000_1434, err_flag=1, ovf=0, out_valid 4 cycles after accept.
//  T2 window mask: g=0x0000_00FF, ep=0x0100_0100 (bits 8,24 excluded/24 kept) -> p=0x0100_00FF, err_flag=1;
//   ep=0x0000_0100 -> p=0x0000_00FF, err_flag=0.
//  T3 carry chain: g=0x00FF_FE00, ep=0x0000_0200 -> p=0x0100_0000 (carry ripples through 2 chunk boundaries);
//   g=0xFFFF_FE00 same ep -> p=0, ovf=1.
//  T4 bypass: g=0xDEAD_BEEF, ep=0x00FF_FE00, en=0 -> p=0xDEAD_BEEF, err_flag=0, same 4-cycle latency.
//  T5 backpressure: out_ready=0 for 6 cycles after out_valid -> p_out stable, in_ready=0; a second in_valid is not accepted;
//   after out_ready=1 the second op is accepted and result correct.
//  T6 reset mid-op: assert rst_n=0 at idx=2 -> outputs zero immediately (async); after release no out_valid; next op correct.

Source files
------------

// File: rtl/error_recovery_unit.sv
// Chunk-serial recovery adder: p = g + (ep masked to the recovery window), one CHUNK per cycle,
// with a registered carry between chunks and valid/ready handshakes on both sides.
module error_recovery_unit #(
  parameter int WIDTH       = 32,
  parameter int CHUNK       = 8,
  parameter int RECOVER_LSB = 9,
  parameter int RECOVER_MSB = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] ep_in,
  input  logic             recover_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic             err_flag,
  output logic             ovf,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_chunk
    $error("error_recovery_unit: WIDTH must be a positive multiple of CHUNK");
  end

  // An inverted window (LSB > MSB) yields an all-zero mask, i.e. permanent bypass.
  function automatic logic [WIDTH-1:0] win_mask();
    logic [WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < WIDTH; k++) m[k] = (k >= RECOVER_LSB) && (k <= RECOVER_MSB);
    return m;
  endfunction

  localparam logic [WIDTH-1:0] MASK = win_mask();

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic             ready_en;
  logic [WIDTH-1:0] g_q, m_q, m_in;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic             accept, last;
  logic [CHUNK:0]   csum;
  int               base;

  assign in_ready  = ready_en && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign last      = (idx == IDXW'(NCHUNK - 1));
  assign m_in      = recover_en ? (ep_in & MASK) : '0;
  assign base      = int'(idx) * CHUNK;

  always_comb begin
    csum = {1'b0, g_q[base +: CHUNK]} + {1'b0, m_q[base +: CHUNK]} + {{CHUNK{1'b0}}, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = ADD;
      ADD:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      g_q      <= '0;
      m_q      <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      p_out    <= '0;
      err_flag <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        g_q      <= g_in;
        m_q      <= m_in;
        err_flag <= |m_in;
        idx      <= '0;
        carry    <= 1'b0;
      end
      if (state == ADD) begin
        p_out[base +: CHUNK] <= csum[CHUNK-1:0];
        carry                <= csum[CHUNK];
        if (last) begin
          ovf <= csum[CHUNK];
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_error_recovery_unit.sv
// Bench for error_recovery_unit: directed cases plus randomized operations against an arithmetic model.
module tb_error_recovery_unit;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [WIDTH-1:0] g_in = '0, ep_in = '0;
  logic             recover_en = 1'b0;
  logic             out_valid, out_ready = 1'b0;
  logic [WIDTH-1:0] p_out;
  logic             err_flag, ovf, busy;

  int n_cmp = 0;
  int n_err = 0;

  error_recovery_unit #(.WIDTH(32), .CHUNK(8), .RECOVER_LSB(9), .RECOVER_MSB(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .g_in(g_in),
    .ep_in(ep_in), .recover_en(recover_en), .out_valid(out_valid), .out_ready(out_ready),
    .p_out(p_out), .err_flag(err_flag), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 33-bit addition of g and the windowed error vector (bits 9..24).
  function automatic logic [33:0] model(input logic [31:0] g, input logic [31:0] ep, input logic en);
    logic [31:0] m;
    logic [32:0] s;
    for (int k = 0; k < 32; k++) m[k] = en && ep[k] && (k >= 9) && (k <= 24);
    s = {1'b0, g} + {1'b0, m};
    return {(m != 0), s};  // {err, ovf, p}
  endfunction

  // Starts and ends on a negedge. Scrambles the operand bus after acceptance.
  task automatic issue(input logic [31:0] g, input logic [31:0] ep, input logic en, output bit ok);
    int w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("in_ready_wait", in_ready, 1'b1);
    ok = in_ready;
    g_in = g; ep_in = ep; recover_en = en; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    g_in = $urandom; ep_in = $urandom; recover_en = 1'($urandom);
  endtask

  task automatic collect(input logic [31:0] g, input logic [31:0] ep, input logic en, input int stall);
    logic [33:0] e;
    logic [31:0] held;
    int lat = 0;
    e = model(g, ep, en);
    do begin
      out_ready = 1'($urandom);  // ignored while no result is presented
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!out_valid && lat < 20);
    chk("latency", lat, 4);
    chk("p_out", p_out, e[31:0]);
    chk("ovf", ovf, e[32]);
    chk("err_flag", err_flag, e[33]);
    held = p_out;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_p", p_out, held);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("drained", out_valid, 1'b0);
  endtask

  task automatic run(input logic [31:0] g, input logic [31:0] ep, input logic en, input int stall);
    bit ok;
    issue(g, ep, en, ok);
    if (ok) collect(g, ep, en, stall);
  endtask

  initial begin
    bit ok;
    logic [31:0] g, ep;
    // reset state
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_p", p_out, 32'h0);
    chk("rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_pre_edge", in_ready, 1'b0);
    @(negedge clk);
    chk("in_ready_post_edge", in_ready, 1'b1);

    // directed cases
    run(32'h0000_1234, 32'h0000_0200, 1'b1, 0);
    chk("T1_p", p_out, 32'h0000_1434);
    run(32'h0000_00FF, 32'h0100_0100, 1'b1, 0);
    chk("T2_p", p_out, 32'h0100_00FF);
    run(32'h0000_00FF, 32'h0000_0100, 1'b1, 0);
    chk("T2_err", err_flag, 1'b0);
    run(32'h00FF_FE00, 32'h0000_0200, 1'b1, 0);
    chk("T3_p", p_out, 32'h0100_0000);
    run(32'hFFFF_FE00, 32'h0000_0200, 1'b1, 0);
    chk("T3_ovf", {ovf, p_out}, 33'h1_0000_0000);
    run(32'hDEAD_BEEF, 32'h00FF_FE00, 1'b0, 0);
    chk("T4_p", p_out, 32'hDEAD_BEEF);

    // backpressure with a competing request held during the stall
    issue(32'h1111_0000, 32'h0000_FE00, 1'b1, ok);
    g_in = 32'h2222_0000; ep_in = 32'h0001_0200; recover_en = 1'b1; in_valid = 1'b1;
    if (ok) collect(32'h1111_0000, 32'h0000_FE00, 1'b1, 6);
    chk("T5_second_waits", in_ready, 1'b1);
    run(32'h2222_0000, 32'h0001_0200, 1'b1, 0);

    // reset mid-operation at idx=2
    issue(32'h1234_5678, 32'h00FF_FE00, 1'b1, ok);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("T6_p", p_out, 32'h0);
    chk("T6_busy", busy, 1'b0);
    chk("T6_flags", {out_valid, err_flag, ovf, in_ready}, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("T6_no_valid", out_valid, 1'b0);
    end
    run(32'hFFFF_FFFF, 32'h01FF_FE00, 1'b1, 1);

    // randomized operations
    for (int i = 0; i < 60; i++) begin
      g  = $urandom;
      ep = $urandom;
      if (($urandom % 4) == 0) g = g | 32'hFFFF_FE00;  // drive long carry chains / overflow
      run(g, ep, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
